// File: rtl/mem_pkg.sv
// Shared types, constants and store-side helpers for the memory access unit.
package mem_pkg;

  localparam int unsigned RAM_AW = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Misaligned halves/words and unused size codes all fault the access.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return lane[0];
      F3_LW:         return (lane != 2'b00);
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return BE_W'(4'b0001 << lane);
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Sub-word stores replicate the low byte/half into every lane.
  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_format.sv
// Selects the addressed byte/half lane of a RAM word and extends it per funct3.
module load_format
  import mem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    result   = word;
    case (addr)
      2'b00: byte_sel = word[7:0];
      2'b01: byte_sel = word[15:8];
      2'b10: byte_sel = word[23:16];
      2'b11: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h000000, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0000, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core FSM and a 4 KB single-port RAM.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [DATA_W-1:0] rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] load_result;

  // Only the 4 KB window of the address reaches the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:12];

  load_format u_load_format (
    .funct3 (f3_q),
    .addr   (lane_q),
    .word   (ram_rdata),
    .result (load_result)
  );

  // Outputs are registered alongside the state so each tracks the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      misalign  <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_en    <= 1'b0;
      ram_be    <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          misalign <= 1'b0;
          ram_en   <= 1'b0;
          ram_be   <= '0;
          if (req) begin
            f3_q   <= funct3;
            lane_q <= addr[1:0];
            busy   <= 1'b1;
            if (access_fault(funct3, addr[1:0])) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else if (req_we) begin
              state     <= ST_WRITE;
              ram_en    <= 1'b1;
              ram_addr  <= addr[11:2];
              ram_be    <= store_be(funct3[1:0], addr[1:0]);
              ram_wdata <= store_data(funct3[1:0], wdata);
            end else begin
              state    <= ST_READ;
              ram_en   <= 1'b1;
              ram_addr <= addr[11:2];
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_READ: begin
          state  <= ST_CAPTURE;
          ram_en <= 1'b0;
        end
        ST_CAPTURE: begin
          state <= ST_DONE;
          rdata <= load_result;
          done  <= 1'b1;
        end
        ST_WRITE: begin
          state  <= ST_DONE;
          ram_en <= 1'b0;
          ram_be <= '0;
          done   <= 1'b1;
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          misalign <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          misalign <= 1'b0;
          ram_en   <= 1'b0;
          ram_be   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req  input  1  access request strobe from the main FSM; sampled only in IDLE.
REQ-004 req_we  input  1  1 = store, 0 = load; sampled with req.
REQ-005 funct3  input  3  RV32I size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-006 addr  input  32  byte address, already selected by the datapath's adrsrc mux.
REQ-007 wdata  input  32  store data; the low byte or half is used for sub-word stores.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 misalign  output  1  fault flag; meaningful only while done=1.
REQ-011 rdata  output  32  formatted load result; registered and held until the next load completes.
REQ-012 ram_addr  output  10  word address, equal to addr[11:2] (4 KB RAM).
REQ-013 ram_en  output  1  RAM access strobe.
REQ-014 ram_be  output  4  byte write enables; all zero for reads.
REQ-015 ram_wdata  output  32  lane-replicated store data.
REQ-016 ram_rdata  input  32  RAM read data, valid one cycle after a read strobe.

Function
REQ-017 States SHALL be IDLE, READ, CAPTURE, WRITE and DONE.
REQ-018 In IDLE with req=1 at cycle N, the unit SHALL latch addr, funct3, wdata and req_we, then branch as follows:
- misaligned or illegal access -> DONE;
- store -> WRITE;
- load -> READ.
REQ-019 The following SHALL count as misaligned or illegal:
- halfword access with addr[0]=1;
- word access with addr[1:0]!=0;
- funct3 of 011, 110 or 111.
REQ-020 A misaligned or illegal access SHALL assert done and misalign at cycle N+1, with no RAM strobe and rdata unchanged.
REQ-021 In READ (cycle N+1), the unit SHALL drive ram_en=1, ram_be=0 and ram_addr=latched addr[11:2].
REQ-022 In CAPTURE (cycle N+2), the unit SHALL register the formatted ram_rdata into rdata, then go to DONE.
- Load latency: done at N+3, and rdata is valid from N+3.
REQ-023 In WRITE (cycle N+1), the unit SHALL drive ram_en=1 with ram_be and ram_wdata as follows, then go to DONE; done rises at N+2 and rdata is unchanged.
- sb: be = 1<<addr[1:0], byte replicated x4.
- sh: be = 0011 if addr[1]=0, else 1100; half replicated x2.
- sw: be = 1111, wdata passed through.
REQ-024 Load formatting SHALL select the byte lane by addr[1:0] or the half lane by addr[1], then extend as follows:
- lb and lh: sign-extend.
- lbu and lhu: zero-extend.
- lw: pass the word through.
REQ-025 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; misalign SHALL be 0 except on faulted accesses.
REQ-026 req SHALL be ignored in every state other than IDLE, including DONE.
- Back-to-back requests: the earliest accepted req is on the cycle after done.
REQ-027 ram_en SHALL be high only in READ or WRITE.
- ram_be SHALL be non-zero only in WRITE.
REQ-028 busy SHALL be a pure function of state, with no combinational path from req.

Reset
REQ-029 reset=1 SHALL force IDLE at the next edge, overriding any request or in-flight access.
REQ-030 Under reset, busy, done, misalign, ram_en, ram_be, ram_wdata, ram_addr and rdata SHALL all be 0.
REQ-031 A reset that arrives mid-access SHALL drop the access: no done pulse, and no RAM strobe after the reset edge.

Structure
REQ-032 Package mem_pkg SHALL hold:
- the state enum;
- funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
- RAM_AW = 10.
REQ-033 Lane selection and extension SHALL live in one combinational sub-module, load_format.
- Ports: funct3, addr[1:0], word in, result out.

Verification
REQ-034 Load byte, sign extension: RAM word 0x0=0x80FF_7F01; lb at addr 0x3 -> rdata=0xFFFF_FF80 at N+3.
- The same access as lbu -> 0x0000_0080.
REQ-035 Store byte: sb addr 0x6, wdata 0x1234_56AB -> in WRITE, ram_addr=1, ram_be=0100, ram_wdata=0xABAB_ABAB; done at N+2.
REQ-036 Misaligned word load: lw addr 0x2 -> done and misalign both 1 at N+1; ram_en never high; rdata keeps its prior value.
REQ-037 Ignored request: req held high through an entire lw -> exactly one access; the next access is accepted in the cycle after done.
REQ-038 Reset mid-load: reset asserted in READ -> IDLE next cycle; no done pulse; all outputs 0.
